timer_preset_programmer: RTL and testbench
==========================================

TIMER_PRESET_PROGRAMMER -- requirements
Module: timer_preset_programmer

Interface
REQ-001 Parameter LOAD_CYCLES, default 2, SHALL set the number of cycles the preset/clear load pattern is held.
REQ-002 Parameter SCAN_DIV, default 1000, SHALL set the clk cycles per display-digit step outside EDIT.
REQ-003 clk  in  1  SHALL be the single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 btn_next  in  1  SHALL be the cursor-advance / enter-edit button level, already synchronised.
REQ-006 btn_inc  in  1  SHALL be the digit-increment button level.
REQ-007 btn_start  in  1  SHALL be the start / abort button level.
REQ-008 timer_zero  in  1  SHALL be high while all four timer digits equal 0.
REQ-009 preset_us, preset_ds, preset_um, preset_dm  out  4 each  SHALL be the per-bit set lines for the timer digits.
REQ-010 clear_us, clear_ds, clear_um, clear_dm  out  4 each  SHALL be the per-bit clear lines for the timer digits.
REQ-011 seletor  out  2  SHALL select the display digit: 0=US, 1=DS, 2=UM, 3=DM.
REQ-012 edit_digit  out  4  SHALL carry the stored value of the digit selected by seletor.
REQ-013 running  out  1  SHALL be high in RUN; valve_off  out  1  SHALL pulse high for one cycle on entry to DONE.

Function
REQ-014 Each button SHALL act only on its rising edge, detected from a registered copy of the previous level.
REQ-015 The FSM SHALL have the states IDLE, EDIT, LOAD, RUN, ABORT and DONE.
REQ-016 IDLE SHALL move to EDIT on a btn_next edge, with cursor=0; other buttons SHALL be ignored in IDLE.
REQ-017 In EDIT, a btn_inc edge SHALL increment the digit at the cursor; US/UM SHALL wrap 9->0 and DS/DM SHALL wrap 5->0.
REQ-018 In EDIT, a btn_next edge SHALL advance the cursor 0->1->2->3->0.
REQ-019 If btn_inc and btn_next edges coincide, the increment SHALL apply to the old cursor and the cursor SHALL then advance.
REQ-020 A btn_start edge in EDIT SHALL win over the other buttons, moving to LOAD if any stored digit is nonzero; otherwise it SHALL be ignored.
REQ-021 LOAD SHALL last exactly LOAD_CYCLES cycles, with preset_x = digit_x and clear_x = ~digit_x for every digit; it SHALL then go to RUN.
REQ-022 Outside LOAD and ABORT, all preset and clear outputs SHALL be 0; no bit SHALL ever have preset and clear high together.
REQ-023 RUN SHALL ignore the timer_zero level for its first cycle and SHALL move to DONE when timer_zero is 1 after that.
REQ-024 A btn_start edge in RUN SHALL move to ABORT, which holds clear_x=4'hF and preset_x=0 for LOAD_CYCLES cycles and then goes to IDLE.
REQ-025 DONE SHALL last one cycle, assert valve_off, and return to IDLE; stored digits SHALL be retained for re-use.
REQ-026 In EDIT, seletor SHALL equal the cursor; elsewhere it SHALL step 0->1->2->3->0 every SCAN_DIV cycles from a free-running counter.
REQ-027 edit_digit SHALL be combinational from seletor and the stored digits.

Reset
REQ-028 Reset SHALL force state=IDLE, cursor=0, all stored digits=0, scan counter=0, seletor=0, and the registered button copies=0.
REQ-029 After reset, the outputs running, valve_off, and all preset/clear lines SHALL be 0 from the first cycle.
REQ-030 Reset asserted during LOAD or ABORT SHALL drop all preset/clear lines to 0 on the next edge.

Structure
REQ-031 A shared package SHALL hold the state enum, the digit limits (MAX_UNIT=9, MAX_TENS=5) and the digit index constants (US=0, DS=1, UM=2, DM=3).
REQ-032 Edge detection SHALL be one sub-module, pulse_edge, instantiated once per button.

Verification
REQ-033 Reset, then btn_next followed by btn_inc x3 -> edit_digit=3, seletor=0; all preset/clear lines = 0.
REQ-034 With cursor=DS, btn_inc x6 -> DS=0; with cursor=US, btn_inc x10 -> US=0 (both wrap).
REQ-035 Set 12:34, then btn_start -> for 2 cycles preset_dm=0001, clear_dm=1110, preset_us=0100, clear_us=1011; then running=1.
REQ-036 In RUN, assert timer_zero -> valve_off is high for exactly 1 cycle, and the state is IDLE on the next cycle.
REQ-037 btn_start in RUN -> all clear_x=1111 for 2 cycles, then IDLE; btn_start in EDIT with all digits 0 -> stays in EDIT.
REQ-038 Reset asserted in the 1st LOAD cycle -> all preset/clear lines are 0 on the next edge, and the stored digits are 0.

Source files
------------

// File: rtl/timer_preset_programmer_pkg.sv
// Shared types and constants for the timer preset programmer.
// Digit indices follow display order: unit/tens seconds, unit/tens minutes.
package timer_preset_programmer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EDIT,
    LOAD,
    RUN,
    ABORT,
    DONE
  } state_t;

  localparam logic [3:0] MAX_UNIT = 4'd9;
  localparam logic [3:0] MAX_TENS = 4'd5;

  localparam logic [1:0] US = 2'd0;
  localparam logic [1:0] DS = 2'd1;
  localparam logic [1:0] UM = 2'd2;
  localparam logic [1:0] DM = 2'd3;

  function automatic logic [3:0] digitMax(input logic [1:0] idx);
    return (idx == DS || idx == DM) ? MAX_TENS : MAX_UNIT;
  endfunction

  function automatic logic [3:0] bumpDigit(
    input logic [3:0] d,
    input logic [1:0] idx
  );
    return (d >= digitMax(idx)) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/timer_preset_programmer_pulse_edge.sv
// Rising-edge detector for an already synchronised button level.
// One-cycle pulse when the level goes from 0 to 1.
module pulse_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prevLevel;

  always_ff @(posedge clk) begin
    if (reset) prevLevel <= 1'b0;
    else       prevLevel <= level;
  end

  assign rise = level & ~prevLevel;

endmodule

// File: rtl/timer_preset_programmer.sv
// Button-driven editor for a 4-digit mm:ss timer that loads the
// preset into the timer digits, runs it, and signals completion.
module timer_preset_programmer
  import timer_preset_programmer_pkg::*;
#(
  parameter int LOAD_CYCLES = 2,
  parameter int SCAN_DIV    = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic       btn_start,
  input  logic       timer_zero,
  output logic [3:0] preset_us,
  output logic [3:0] preset_ds,
  output logic [3:0] preset_um,
  output logic [3:0] preset_dm,
  output logic [3:0] clear_us,
  output logic [3:0] clear_ds,
  output logic [3:0] clear_um,
  output logic [3:0] clear_dm,
  output logic [1:0] seletor,
  output logic [3:0] edit_digit,
  output logic       running,
  output logic       valve_off
);

  localparam int CW = $clog2(LOAD_CYCLES + 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  state_t          state;
  state_t          stateNext;
  logic [CW-1:0]   phaseCnt;
  logic [CW-1:0]   phaseCntNext;
  logic [1:0]      cursor;
  logic [3:0]      digits [4];
  logic [SW-1:0]   scanCnt;
  logic [1:0]      scanSel;
  logic            nextEdge;
  logic            incEdge;
  logic            startEdge;
  logic            anySet;
  logic            loadGo;

  pulse_edge uNext (
    .clk   (clk),
    .reset (reset),
    .level (btn_next),
    .rise  (nextEdge)
  );

  pulse_edge uInc (
    .clk   (clk),
    .reset (reset),
    .level (btn_inc),
    .rise  (incEdge)
  );

  pulse_edge uStart (
    .clk   (clk),
    .reset (reset),
    .level (btn_start),
    .rise  (startEdge)
  );

  assign anySet = |{digits[US], digits[DS], digits[UM], digits[DM]};
  assign loadGo = (state == EDIT) && startEdge && anySet;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      phaseCnt <= '0;
    end else begin
      state    <= stateNext;
      phaseCnt <= phaseCntNext;
    end
  end

  // In RUN, phaseCnt only marks that the first cycle has passed.
  always_comb begin
    stateNext    = state;
    phaseCntNext = phaseCnt;
    running      = 1'b0;
    valve_off    = 1'b0;
    preset_us    = 4'h0;
    preset_ds    = 4'h0;
    preset_um    = 4'h0;
    preset_dm    = 4'h0;
    clear_us     = 4'h0;
    clear_ds     = 4'h0;
    clear_um     = 4'h0;
    clear_dm     = 4'h0;
    unique case (state)
      IDLE: begin
        if (nextEdge) stateNext = EDIT;
      end
      EDIT: begin
        if (loadGo) begin
          stateNext    = LOAD;
          phaseCntNext = '0;
        end
      end
      LOAD: begin
        preset_us = digits[US];
        preset_ds = digits[DS];
        preset_um = digits[UM];
        preset_dm = digits[DM];
        clear_us  = ~digits[US];
        clear_ds  = ~digits[DS];
        clear_um  = ~digits[UM];
        clear_dm  = ~digits[DM];
        if (phaseCnt == LOAD_LAST) begin
          stateNext    = RUN;
          phaseCntNext = '0;
        end else begin
          phaseCntNext = phaseCnt + CW'(1);
        end
      end
      RUN: begin
        running = 1'b1;
        if (startEdge) begin
          stateNext    = ABORT;
          phaseCntNext = '0;
        end else if (phaseCnt != '0 && timer_zero) begin
          stateNext = DONE;
        end else begin
          phaseCntNext = CW'(1);
        end
      end
      ABORT: begin
        clear_us = 4'hF;
        clear_ds = 4'hF;
        clear_um = 4'hF;
        clear_dm = 4'hF;
        if (phaseCnt == LOAD_LAST) begin
          stateNext    = IDLE;
          phaseCntNext = '0;
        end else begin
          phaseCntNext = phaseCnt + CW'(1);
        end
      end
      DONE: begin
        valve_off = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Increment uses the old cursor; a simultaneous advance lands after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cursor <= '0;
      for (int i = 0; i < 4; i++) digits[i] <= '0;
    end else if (state == IDLE && nextEdge) begin
      cursor <= '0;
    end else if (state == EDIT && !loadGo) begin
      if (incEdge) digits[cursor] <= bumpDigit(digits[cursor], cursor);
      if (nextEdge) cursor <= cursor + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scanCnt <= '0;
      scanSel <= '0;
    end else if (scanCnt == SCAN_LAST) begin
      scanCnt <= '0;
      scanSel <= scanSel + 2'd1;
    end else begin
      scanCnt <= scanCnt + SW'(1);
    end
  end

  assign seletor    = (state == EDIT) ? cursor : scanSel;
  assign edit_digit = digits[seletor];

endmodule

// File: tb/tb_timer_preset_programmer.sv
// Bench for timer_preset_programmer: vector table, corner sequences,
// and random stimulus against a cycle-level behavioural model.
module tb_timer_preset_programmer;

  localparam int SCAN  = 4;
  localparam int LOADN = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_next = 1'b0;
  logic btn_inc = 1'b0;
  logic btn_start = 1'b0;
  logic timer_zero = 1'b0;
  logic [3:0] preset_us, preset_ds, preset_um, preset_dm;
  logic [3:0] clear_us, clear_ds, clear_um, clear_dm;
  logic [1:0] seletor;
  logic [3:0] edit_digit;
  logic running, valve_off;

  int passCnt = 0;
  int totalCnt = 0;

  timer_preset_programmer #(
    .LOAD_CYCLES (LOADN),
    .SCAN_DIV    (SCAN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_next   (btn_next),
    .btn_inc    (btn_inc),
    .btn_start  (btn_start),
    .timer_zero (timer_zero),
    .preset_us  (preset_us),
    .preset_ds  (preset_ds),
    .preset_um  (preset_um),
    .preset_dm  (preset_dm),
    .clear_us   (clear_us),
    .clear_ds   (clear_ds),
    .clear_um   (clear_um),
    .clear_dm   (clear_dm),
    .seletor    (seletor),
    .edit_digit (edit_digit),
    .running    (running),
    .valve_off  (valve_off)
  );

  always #5 clk = ~clk;

  typedef enum int {mIdle, mEdit, mLoad, mRun, mAbort, mDone} modeT;
  modeT mMode = mIdle;
  int mAge = 0;
  int mCur = 0;
  int mTicks = 0;
  int mDig [4] = '{0, 0, 0, 0};
  bit pN = 0, pI = 0, pS = 0;

  function automatic void check(string nm, logic [63:0] act,
                                logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endfunction

  // Model: mode, time spent in mode, digit values, total cycles since reset.
  task automatic modelStep();
    bit en, ei, es;
    modeT nm;
    int lim;
    if (reset) begin
      mMode = mIdle; mAge = 0; mCur = 0; mTicks = 0;
      for (int i = 0; i < 4; i++) mDig[i] = 0;
      pN = 0; pI = 0; pS = 0;
      return;
    end
    en = btn_next && !pN;
    ei = btn_inc && !pI;
    es = btn_start && !pS;
    pN = btn_next; pI = btn_inc; pS = btn_start;
    mTicks++;
    nm = mMode;
    case (mMode)
      mIdle: if (en) begin nm = mEdit; mCur = 0; end
      mEdit: begin
        if (es && (mDig[0] + mDig[1] + mDig[2] + mDig[3]) > 0) begin
          nm = mLoad;
        end else begin
          if (ei) begin
            lim = (mCur % 2 == 1) ? 5 : 9;
            mDig[mCur] = (mDig[mCur] + 1) % (lim + 1);
          end
          if (en) mCur = (mCur + 1) % 4;
        end
      end
      mLoad:  if (mAge + 1 == LOADN) nm = mRun;
      mRun: begin
        if (es) nm = mAbort;
        else if (mAge >= 1 && timer_zero) nm = mDone;
      end
      mAbort: if (mAge + 1 == LOADN) nm = mIdle;
      default: nm = mIdle;
    endcase
    if (nm != mMode) begin mMode = nm; mAge = 0; end
    else mAge++;
  endtask

  function automatic logic [39:0] modelVec();
    int sel;
    logic [3:0] p [4];
    logic [3:0] c [4];
    sel = (mMode == mEdit) ? mCur : (mTicks / SCAN) % 4;
    for (int i = 0; i < 4; i++) begin
      p[i] = (mMode == mLoad) ? 4'(mDig[i]) : 4'h0;
      c[i] = (mMode == mLoad) ? ~4'(mDig[i]) :
             (mMode == mAbort) ? 4'hF : 4'h0;
    end
    return {mMode == mRun, mMode == mDone, 2'(sel), 4'(mDig[sel]),
            p[0], p[1], p[2], p[3], c[0], c[1], c[2], c[3]};
  endfunction

  function automatic logic [39:0] dutVec();
    return {running, valve_off, seletor, edit_digit,
            preset_us, preset_ds, preset_um, preset_dm,
            clear_us, clear_ds, clear_um, clear_dm};
  endfunction

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    check("model", dutVec(), modelVec());
    check("overlap", {preset_us & clear_us, preset_ds & clear_ds,
                      preset_um & clear_um, preset_dm & clear_dm}, 0);
  endtask

  task automatic press(input int which);
    case (which)
      0: btn_next = 1'b1;
      1: btn_inc = 1'b1;
      default: btn_start = 1'b1;
    endcase
    tick();
    btn_next = 1'b0; btn_inc = 1'b0; btn_start = 1'b0;
    tick();
  endtask

  typedef struct {
    logic rst, nxt, inc, st, tz;
    logic eRun, eValve;
    logic [1:0] eSel;
    logic [3:0] eEdit, ePUs, eCUs, ePDm, eCDm;
  } vecT;

  vecT tbl [$];

  function automatic void row(
    logic r, logic n, logic i, logic s, logic z,
    logic eR, logic eV, logic [1:0] sel, logic [3:0] ed,
    logic [3:0] pu, logic [3:0] cu, logic [3:0] pd, logic [3:0] cd);
    vecT v;
    v.rst = r; v.nxt = n; v.inc = i; v.st = s; v.tz = z;
    v.eRun = eR; v.eValve = eV; v.eSel = sel; v.eEdit = ed;
    v.ePUs = pu; v.eCUs = cu; v.ePDm = pd; v.eCDm = cd;
    tbl.push_back(v);
  endfunction

  initial begin
    // Build 12:34 (DM=1 UM=2 DS=3 US=4), load, run, finish on timer_zero.
    row(1,0,0,0,0, 0,0,0,0, 0,0,0,0);
    row(0,1,0,0,0, 0,0,0,0, 0,0,0,0);
    row(0,0,0,0,0, 0,0,0,0, 0,0,0,0);
    row(0,0,1,0,0, 0,0,0,1, 0,0,0,0);
    row(0,0,0,0,0, 0,0,0,1, 0,0,0,0);
    row(0,0,1,0,0, 0,0,0,2, 0,0,0,0);
    row(0,0,0,0,0, 0,0,0,2, 0,0,0,0);
    row(0,0,1,0,0, 0,0,0,3, 0,0,0,0);
    row(0,0,0,0,0, 0,0,0,3, 0,0,0,0);
    row(0,0,1,0,0, 0,0,0,4, 0,0,0,0);
    row(0,0,0,0,0, 0,0,0,4, 0,0,0,0);
    row(0,1,0,0,0, 0,0,1,0, 0,0,0,0);
    row(0,0,0,0,0, 0,0,1,0, 0,0,0,0);
    row(0,0,1,0,0, 0,0,1,1, 0,0,0,0);
    row(0,0,0,0,0, 0,0,1,1, 0,0,0,0);
    row(0,0,1,0,0, 0,0,1,2, 0,0,0,0);
    row(0,0,0,0,0, 0,0,1,2, 0,0,0,0);
    row(0,1,1,0,0, 0,0,2,0, 0,0,0,0);
    row(0,0,0,0,0, 0,0,2,0, 0,0,0,0);
    row(0,0,1,0,0, 0,0,2,1, 0,0,0,0);
    row(0,0,0,0,0, 0,0,2,1, 0,0,0,0);
    row(0,0,1,0,0, 0,0,2,2, 0,0,0,0);
    row(0,0,0,0,0, 0,0,2,2, 0,0,0,0);
    row(0,1,0,0,0, 0,0,3,0, 0,0,0,0);
    row(0,0,0,0,0, 0,0,3,0, 0,0,0,0);
    row(0,0,1,0,0, 0,0,3,1, 0,0,0,0);
    row(0,0,0,0,0, 0,0,3,1, 0,0,0,0);
    row(0,0,0,1,0, 0,0,2,2, 4'h4,4'hB,4'h1,4'hE);
    row(0,0,0,0,0, 0,0,3,1, 4'h4,4'hB,4'h1,4'hE);
    row(0,0,0,0,0, 1,0,3,1, 0,0,0,0);
    row(0,0,0,0,1, 1,0,3,1, 0,0,0,0);
    row(0,0,0,0,1, 0,1,3,1, 0,0,0,0);
    row(0,0,0,0,1, 0,0,0,4, 0,0,0,0);
    row(0,0,0,0,0, 0,0,0,4, 0,0,0,0);

    for (int k = 0; k < tbl.size(); k++) begin
      reset = tbl[k].rst; btn_next = tbl[k].nxt; btn_inc = tbl[k].inc;
      btn_start = tbl[k].st; timer_zero = tbl[k].tz;
      tick();
      check($sformatf("vec%0d", k),
            {running, valve_off, seletor, edit_digit,
             preset_us, clear_us, preset_dm, clear_dm},
            {tbl[k].eRun, tbl[k].eValve, tbl[k].eSel, tbl[k].eEdit,
             tbl[k].ePUs, tbl[k].eCUs, tbl[k].ePDm, tbl[k].eCDm});
    end
    reset = 0; btn_next = 0; btn_inc = 0; btn_start = 0; timer_zero = 0;

    // Abort from RUN with the stored 12:34.
    press(0);
    btn_start = 1'b1; tick();
    check("abortLoad1", {running, clear_dm, preset_us}, {1'b0, 4'hE, 4'h4});
    btn_start = 1'b0; tick(); tick();
    check("abortRun", running, 1);
    btn_start = 1'b1; tick();
    check("abortClr1", {clear_us, clear_ds, clear_um, clear_dm,
                        preset_us, preset_ds, preset_um, preset_dm},
          {16'hFFFF, 16'h0000});
    btn_start = 1'b0; tick();
    check("abortClr2", {clear_us, clear_ds, clear_um, clear_dm,
                        preset_us, preset_ds, preset_um, preset_dm},
          {16'hFFFF, 16'h0000});
    tick();
    check("abortIdle", {running, clear_us, clear_ds, clear_um, clear_dm},
          0);

    // Start with all digits zero stays in EDIT.
    reset = 1'b1; tick(); reset = 1'b0;
    press(0);
    btn_start = 1'b1; tick();
    check("startZero", {running, seletor, clear_us, clear_dm, preset_us},
          0);
    btn_start = 1'b0; tick();

    // Wrap of unit seconds, then tens seconds.
    for (int j = 1; j <= 10; j++) begin
      press(1);
      if (j == 9) check("usNine", {seletor, edit_digit}, {2'd0, 4'd9});
      if (j == 10) check("usWrap", {seletor, edit_digit}, {2'd0, 4'd0});
    end
    press(0);
    for (int j = 1; j <= 6; j++) begin
      press(1);
      if (j == 5) check("dsFive", {seletor, edit_digit}, {2'd1, 4'd5});
      if (j == 6) check("dsWrap", {seletor, edit_digit}, {2'd1, 4'd0});
    end

    // Reset in the first LOAD cycle.
    press(1);
    btn_start = 1'b1; tick();
    check("loadPre", {preset_ds, clear_ds}, {4'h1, 4'hE});
    reset = 1'b1; btn_start = 1'b0; tick();
    check("rstLoad", {preset_us, preset_ds, preset_um, preset_dm,
                      clear_us, clear_ds, clear_um, clear_dm,
                      running, edit_digit}, 0);
    reset = 1'b0;
    for (int j = 0; j < 16; j++) begin
      tick();
      check("rstDigits", edit_digit, 0);
    end

    // Random stimulus against the model.
    for (int k = 0; k < 4000; k++) begin
      reset      = ($urandom_range(0, 599) == 0);
      btn_next   = ($urandom_range(0, 3) == 0);
      btn_inc    = ($urandom_range(0, 2) == 0);
      btn_start  = ($urandom_range(0, 9) == 0);
      timer_zero = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
